cpstr_mgr_tx: RTL and testbench
===============================

CPSTR_MGR_TX -- requirements
Module: cpstr_mgr_tx

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 4, number of source streams (legal 1..16).
REQ-002 SHALL have parameter ESC_CHAR, default 8'h1B, the escape byte.
REQ-003 SHALL have parameter MAX_BURST, default 16, the most input bytes accepted per grant before re-arbitration (legal 1..255).
REQ-004 SHALL have port i_clk  in  1  the single clock; all state on rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_data  in  8*NUM_STREAMS  source bytes, stream k at bits [8k+7:8k].
REQ-007 SHALL have port i_valid  in  NUM_STREAMS  per-stream valid.
REQ-008 SHALL have port o_ready  out  NUM_STREAMS  per-stream ready; at most one bit high.
REQ-009 SHALL have port o_data  out  8  muxed, escaped output byte (registered).
REQ-010 SHALL have port o_valid  out  1  output valid (registered).
REQ-011 SHALL have port i_ready  in  1  downstream ready.
REQ-012 SHALL have port i_send_stridx  in  1  single-cycle request to re-announce the current stream index (driven by the RX manager).
REQ-013 SHALL have port o_stridx  out  4  index of the currently announced stream.

Function
REQ-014 SHALL transfer a byte on any interface only in a cycle where valid and ready are both high.
REQ-015 SHALL hold o_data and o_valid stable while o_valid=1 and i_ready=0.
REQ-016 SHALL have an output slot free when o_valid=0 or i_ready=1; all byte emission happens only in a free slot.
REQ-017 SHALL use FSM states IDLE, SEL_ESC, SEL_IDX, DATA and DATA_ESC.
REQ-018 SHALL, in IDLE with a free slot, service a pending stridx request first: go to SEL_ESC with the index unchanged.
REQ-019 SHALL otherwise, in IDLE, grant round-robin the lowest index above the last grant (wrapping) that has i_valid high, and stay in IDLE if no i_valid is high.
REQ-020 SHALL go from IDLE to DATA when the winner equals o_stridx and an index has been announced since reset; otherwise it SHALL go to SEL_ESC.
REQ-021 SHALL emit ESC_CHAR in SEL_ESC, then emit {4'h0, idx} in SEL_IDX; on that emission o_stridx SHALL update to idx, the announced flag SHALL set and the pending request SHALL clear; the next state SHALL be DATA if a grant exists, else IDLE.
REQ-022 SHALL, in DATA, drive o_ready[grant] = free slot, with all other o_ready bits 0, and SHALL hold all o_ready low in every other state.
REQ-023 SHALL emit an accepted byte B != ESC_CHAR as-is in the next cycle (latency 1).
REQ-024 SHALL emit an accepted byte B == ESC_CHAR as ESC_CHAR, then enter DATA_ESC, which emits a second ESC_CHAR without consuming input and returns to DATA.
REQ-025 SHALL count accepted bytes per grant, and SHALL enter IDLE (after DATA_ESC if pending) when the count reaches MAX_BURST or the granted i_valid is low in a free DATA slot.
REQ-026 SHALL latch i_send_stridx into a pending flag; repeated requests while pending SHALL yield one announcement; a request coinciding with the clearing emission SHALL stay pending.
REQ-027 SHALL let a stream switch announcement satisfy any pending request.
REQ-028 SHALL never produce a select byte equal to ESC_CHAR or 8'hFF (guaranteed by NUM_STREAMS<=16).

Reset
REQ-029 SHALL, while i_rst is high, force: state IDLE, o_valid 0, o_data 8'h00, o_ready all 0, o_stridx 0, last grant NUM_STREAMS-1, announced flag 0, pending 0, burst count 0.
REQ-030 SHALL, when reset is asserted mid-sequence (including between the two ESC bytes), abandon that sequence with no resume; the first grant after reset SHALL always emit a select sequence.

Configuration
REQ-031 SHALL, when macro CPSTR_MGR_TX_STRIDX_REQ_EN is defined, honour i_send_stridx per REQ-018/026.
REQ-032 SHALL, when CPSTR_MGR_TX_STRIDX_REQ_EN is undefined, keep the i_send_stridx port but ignore it, with pending constant 0; announcements then occur only on stream switches.

Verification
REQ-033 SHALL verify: after reset, stream 2 sends 0x41,0x42 with i_ready=1 -> output 1B,02,41,42; o_stridx=2.
REQ-034 SHALL verify: stream 0 sends 0x1B -> output 1B,00,1B,1B, with o_ready[0] low during the second 1B.
REQ-035 SHALL verify: streams 0 and 1 each hold 20 bytes, MAX_BURST=16 -> 1B,00, 16 bytes of stream 0, 1B,01, 16 bytes of stream 1, 1B,00, 4 bytes, 1B,01, 4 bytes.
REQ-036 SHALL verify: i_ready held low 5 cycles mid-burst -> o_data/o_valid frozen, no byte lost or duplicated.
REQ-037 SHALL verify: macro defined, idle after stream 3, i_send_stridx pulsed twice -> exactly one 1B,03; macro undefined -> no output.
REQ-038 SHALL verify: i_rst asserted the cycle after the first 1B of an escaped pair -> o_valid=0 next edge; the next stream 0 byte 0x55 yields 1B,00,55.

Source files
------------

// File: rtl/cpstr_mgr_tx.sv
// cpstr_mgr_tx: multi-stream transmit manager. Arbitrates NUM_STREAMS byte
// sources round-robin onto one output, announces stream switches with
// ESC_CHAR followed by {4'h0, idx}, and doubles any ESC_CHAR in the payload.
// Optional feature macro: CPSTR_MGR_TX_STRIDX_REQ_EN -- when defined, a pulse
// on i_send_stridx re-announces the current stream index; when undefined the
// port is present but ignored.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_data, i_valid   per-stream source bytes (stream k at [8k+7:8k]) / valids
//   o_ready           per-stream ready, at most one bit high
//   o_data, o_valid   registered output byte stream
//   i_ready           downstream ready
//   i_send_stridx     single-cycle request to re-announce the stream index
//   o_stridx          index of the currently announced stream
module cpstr_mgr_tx #(
  parameter int unsigned NUM_STREAMS = 4,
  parameter logic [7:0]  ESC_CHAR    = 8'h1B,
  parameter int unsigned MAX_BURST   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [8*NUM_STREAMS-1:0] i_data,
  input  logic [NUM_STREAMS-1:0]   i_valid,
  output logic [NUM_STREAMS-1:0]   o_ready,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  input  logic                     i_send_stridx,
  output logic [3:0]               o_stridx
);

`ifdef CPSTR_MGR_TX_STRIDX_REQ_EN
  localparam bit REQ_EN = 1'b1;
`else
  localparam bit REQ_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SEL_ESC, SEL_IDX, DATA, DATA_ESC} state_t;

  state_t     state, state_n;
  logic [3:0] grant, grant_n, sel_idx, sel_idx_n, stridx_n;
  logic       grant_vld, grant_vld_n;   // a stream grant follows the select sequence
  logic       announced, announced_n;
  logic       pending, pending_n;
  logic       esc_exit, esc_exit_n;     // burst ended on an escaped byte
  logic [7:0] burst_cnt, burst_cnt_n;
  logic [7:0] o_data_n;
  logic       o_valid_n;

  logic       free;
  logic       req_in;
  logic       gnt_valid;
  logic [7:0] gnt_data;
  logic       win_found;
  logic [3:0] win_idx;
  logic       burst_done;

  assign free   = !o_valid || i_ready;
  assign req_in = REQ_EN & i_send_stridx;

  // Granted-stream mux
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = 8'h00;
    for (int k = 0; k < int'(NUM_STREAMS); k++) begin
      if (grant == 4'(k)) begin
        gnt_valid = i_valid[k];
        gnt_data  = i_data[8*k +: 8];
      end
    end
  end

  // Ready is offered only to the granted stream while in DATA
  always_comb begin
    o_ready = '0;
    if (state == DATA) begin
      for (int k = 0; k < int'(NUM_STREAMS); k++) begin
        if (grant == 4'(k)) o_ready[k] = free;
      end
    end
  end

  // Round-robin: first valid stream above the last grant, wrapping
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = grant;
    for (int off = 1; off <= int'(NUM_STREAMS); off++) begin
      cand = int'(grant) + off;
      if (cand >= int'(NUM_STREAMS)) cand = cand - int'(NUM_STREAMS);
      for (int k = 0; k < int'(NUM_STREAMS); k++) begin
        if (!win_found && cand == k && i_valid[k]) begin
          win_found = 1'b1;
          win_idx   = 4'(k);
        end
      end
    end
  end

  assign burst_done = (9'(burst_cnt) + 9'd1) == 9'(MAX_BURST);

  // Next-state and output logic
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    sel_idx_n   = sel_idx;
    stridx_n    = o_stridx;
    grant_vld_n = grant_vld;
    announced_n = announced;
    pending_n   = pending | req_in;
    esc_exit_n  = esc_exit;
    burst_cnt_n = burst_cnt;
    o_data_n    = o_data;
    o_valid_n   = free ? 1'b0 : o_valid;

    case (state)
      IDLE: begin
        if (pending && free) begin
          state_n     = SEL_ESC;
          sel_idx_n   = o_stridx;
          grant_vld_n = 1'b0;
        end else if (win_found) begin
          grant_n     = win_idx;
          burst_cnt_n = 8'd0;
          if (announced && win_idx == o_stridx) begin
            state_n = DATA;
          end else begin
            state_n     = SEL_ESC;
            sel_idx_n   = win_idx;
            grant_vld_n = 1'b1;
          end
        end
      end
      SEL_ESC: begin
        if (free) begin
          o_data_n  = ESC_CHAR;
          o_valid_n = 1'b1;
          state_n   = SEL_IDX;
        end
      end
      SEL_IDX: begin
        if (free) begin
          o_data_n    = {4'h0, sel_idx};
          o_valid_n   = 1'b1;
          stridx_n    = sel_idx;
          announced_n = 1'b1;
          // A request arriving with this emission stays pending
          pending_n   = req_in;
          state_n     = grant_vld ? DATA : IDLE;
        end
      end
      DATA: begin
        if (free) begin
          if (gnt_valid) begin
            o_data_n    = gnt_data;
            o_valid_n   = 1'b1;
            burst_cnt_n = burst_cnt + 8'd1;
            if (gnt_data == ESC_CHAR) begin
              state_n    = DATA_ESC;
              esc_exit_n = burst_done;
            end else if (burst_done) begin
              state_n = IDLE;
            end
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA_ESC: begin
        if (free) begin
          o_data_n  = ESC_CHAR;
          o_valid_n = 1'b1;
          state_n   = esc_exit ? IDLE : DATA;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      grant     <= 4'(NUM_STREAMS - 1);
      sel_idx   <= 4'h0;
      o_stridx  <= 4'h0;
      grant_vld <= 1'b0;
      announced <= 1'b0;
      pending   <= 1'b0;
      esc_exit  <= 1'b0;
      burst_cnt <= 8'd0;
      o_data    <= 8'h00;
      o_valid   <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      sel_idx   <= sel_idx_n;
      o_stridx  <= stridx_n;
      grant_vld <= grant_vld_n;
      announced <= announced_n;
      pending   <= pending_n;
      esc_exit  <= esc_exit_n;
      burst_cnt <= burst_cnt_n;
      o_data    <= o_data_n;
      o_valid   <= o_valid_n;
    end
  end

endmodule

// File: tb/tb_cpstr_mgr_tx.sv
// Scoreboard bench for cpstr_mgr_tx: sources and sink are serviced on the
// falling edge; expected output bytes are queued by the directed tests and
// popped by the monitor on every output handshake.
module tb_cpstr_mgr_tx;
  localparam int NS = 4;

  logic              i_clk;
  logic              i_rst;
  logic [8*NS-1:0]   i_data;
  logic [NS-1:0]     i_valid;
  logic [NS-1:0]     o_ready;
  logic [7:0]        o_data;
  logic              o_valid;
  logic              i_ready;
  logic              i_send_stridx;
  logic [3:0]        o_stridx;

  cpstr_mgr_tx #(.NUM_STREAMS(NS), .ESC_CHAR(8'h1B), .MAX_BURST(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .i_send_stridx(i_send_stridx), .o_stridx(o_stridx)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          errors = 0;
  int          nout   = 0;
  int          rdy_chk_at = -1;
  logic        stall  = 1'b0;
  logic        prev_stalled = 1'b0;
  logic [7:0]  held = 8'h00;
  logic [7:0]  exp_q[$];
  logic [7:0]  src_mem [NS][128];
  int          src_wr [NS];
  int          src_rd [NS];
  logic        src_fire [NS];

  initial begin
    for (int k = 0; k < NS; k++) begin
      src_wr[k] = 0; src_rd[k] = 0; src_fire[k] = 1'b0;
    end
  end

  // Source driver, sink and scoreboard monitor
  always @(negedge i_clk) begin
    logic [7:0] e;
    for (int k = 0; k < NS; k++) begin
      if (src_fire[k]) src_rd[k] = src_rd[k] + 1;
      src_fire[k] = 1'b0;
    end
    i_ready = !stall;
    for (int k = 0; k < NS; k++) begin
      if (src_rd[k] < src_wr[k]) begin
        i_valid[k] = 1'b1;
        i_data[8*k +: 8] = src_mem[k][src_rd[k]];
      end else begin
        i_valid[k] = 1'b0;
        i_data[8*k +: 8] = 8'h00;
      end
    end
    #1;
    if (i_rst) begin
      prev_stalled = 1'b0;
    end else begin
      for (int k = 0; k < NS; k++) src_fire[k] = i_valid[k] && o_ready[k];
      if (prev_stalled) begin
        checks++;
        if (!(o_valid === 1'b1 && o_data === held)) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%02h, want valid=1 data=%02h",
                   o_valid, o_data, held);
        end
      end
      if (o_valid && i_ready) begin
        prev_stalled = 1'b0;
        checks++;
        nout++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, want no output", o_data);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e) begin
            errors++;
            $display("FAIL out_byte#%0d: got %02h, want %02h", nout, o_data, e);
          end
        end
        // While the second ESC of a doubled pair is produced, no input is taken
        if (nout == rdy_chk_at) begin
          checks++;
          if (o_ready !== '0) begin
            errors++;
            $display("FAIL ready_in_esc: got o_ready=%b, want 0000", o_ready);
          end
        end
      end else if (o_valid) begin
        held = o_data;
        prev_stalled = 1'b1;
      end else begin
        prev_stalled = 1'b0;
      end
    end
  end

  task automatic load(input int s, input logic [7:0] b);
    src_mem[s][src_wr[s]] = b;
    src_wr[s] = src_wr[s] + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic wait_out(input int target, input string what);
    int n;
    n = 0;
    while (nout < target && n < 2000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (nout < target) begin
      checks++; errors++;
      $display("FAIL timeout_%s: got %0d bytes, want %0d", what, nout, target);
    end
  endtask

  task automatic drain(input string what);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge i_clk); #1;
      n++;
    end
    repeat (6) begin @(posedge i_clk); #1; end
    chk({"drain_", what}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    i_rst = 1'b1;
    i_send_stridx = 1'b0;
    repeat (3) begin @(posedge i_clk); #1; end
    chk("rst_o_valid",  32'(o_valid),  32'd0);
    chk("rst_o_data",   32'(o_data),   32'h00);
    chk("rst_o_ready",  32'(o_ready),  32'd0);
    chk("rst_o_stridx", 32'(o_stridx), 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Stream 2 sends two plain bytes
    load(2, 8'h41); load(2, 8'h42);
    exp_q.push_back(8'h1B); exp_q.push_back(8'h02);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    drain("s2");
    chk("stridx_s2", 32'(o_stridx), 32'd2);

    // Streams 0 and 1 with 20 bytes each, bursts capped at 16
    for (int i = 0; i < 20; i++) begin
      load(0, 8'(8'h20 + i));
      load(1, 8'(8'h60 + i));
    end
    exp_q.push_back(8'h1B); exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h20 + i));
    exp_q.push_back(8'h1B); exp_q.push_back(8'h01);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h60 + i));
    exp_q.push_back(8'h1B); exp_q.push_back(8'h00);
    for (int i = 16; i < 20; i++) exp_q.push_back(8'(8'h20 + i));
    exp_q.push_back(8'h1B); exp_q.push_back(8'h01);
    for (int i = 16; i < 20; i++) exp_q.push_back(8'(8'h60 + i));
    drain("burst");
    chk("stridx_burst", 32'(o_stridx), 32'd1);

    // Stream 0 sends an escape byte, which is doubled
    base = nout;
    rdy_chk_at = base + 3;
    load(0, 8'h1B);
    exp_q.push_back(8'h1B); exp_q.push_back(8'h00);
    exp_q.push_back(8'h1B); exp_q.push_back(8'h1B);
    drain("esc");
    chk("stridx_esc", 32'(o_stridx), 32'd0);
    rdy_chk_at = -1;

    // Downstream stall of 5 cycles mid-burst
    base = nout;
    for (int i = 0; i < 8; i++) load(3, 8'(8'h70 + i));
    exp_q.push_back(8'h1B); exp_q.push_back(8'h03);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h70 + i));
    wait_out(base + 4, "stall");
    stall = 1'b1;
    repeat (5) begin @(posedge i_clk); #1; end
    stall = 1'b0;
    drain("stall");

    // Two re-announce pulses while idle on stream 3
    @(posedge i_clk); #1; i_send_stridx = 1'b1;
    @(posedge i_clk); #1; i_send_stridx = 1'b0;
    @(posedge i_clk); #1; i_send_stridx = 1'b1;
    @(posedge i_clk); #1; i_send_stridx = 1'b0;
`ifdef CPSTR_MGR_TX_STRIDX_REQ_EN
    exp_q.push_back(8'h1B); exp_q.push_back(8'h03);
`endif
    drain("stridx_req");
    chk("stridx_req_idle", 32'(o_valid), 32'd0);

    // Reset between the two bytes of a doubled escape
    base = nout;
    load(0, 8'h1B);
    exp_q.push_back(8'h1B); exp_q.push_back(8'h00); exp_q.push_back(8'h1B);
    wait_out(base + 3, "pre_rst");
    i_rst = 1'b1;
    exp_q.delete();
    @(posedge i_clk); #1;
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_o_ready", 32'(o_ready), 32'd0);
    chk("midrst_o_stridx", 32'(o_stridx), 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    load(0, 8'h55);
    exp_q.push_back(8'h1B); exp_q.push_back(8'h00); exp_q.push_back(8'h55);
    drain("post_rst");
    chk("stridx_post_rst", 32'(o_stridx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
